// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the FABulous column configuration loader.
// Holds the bitstream control words, the header field bounds and the
// loader state type. Imported by frame_config_loader.
// No ports (package).
package frame_cfg_pkg;

  // Control words recognised in the bitstream
  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'h0000_DE5C;

  // Header layout: frame index lives in the low byte, the rest is ignored
  localparam int FRAME_IDX_LSB = 0;
  localparam int FRAME_IDX_MSB = 7;
  localparam int FRAME_IDX_W   = FRAME_IDX_MSB - FRAME_IDX_LSB + 1;

  // CHK is only reachable when the checksum feature is compiled in
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CHK,
    SETTLE,
    STROBE
  } frame_state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decoder producing the FrameStrobe write pulse.
// A pulse is launched on the edge where fire is high and appears on strobe
// for the following cycle only.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   idx    in   frame index to decode (must be < MaxFramesPerCol)
//   fire   in   launch a pulse for idx on this edge
//   strobe out  registered one-hot strobe, all zero when idle
module frame_strobe_decoder #(
  parameter int MaxFramesPerCol = 20,
  parameter int IdxW            = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IdxW-1:0]            idx,
  input  logic                       fire,
  output logic [MaxFramesPerCol-1:0] strobe
);

  logic [MaxFramesPerCol-1:0] strobe_d;
  logic [MaxFramesPerCol-1:0] strobe_q;

  // Per-bit compare rather than a shift so an out-of-range index can never
  // light a bit; at most one bit can match.
  always_comb begin
    strobe_d = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      if (fire && (idx == IdxW'(i))) begin
        strobe_d[i] = 1'b1;
      end
    end
  end

  // Reset drops any pulse straight to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/frame_config_loader.sv
// Configuration front-end for a two-row FABulous supertile column.
// Consumes a 32-bit bitstream over valid/ready, decodes sync/header/desync
// words, assembles one FrameData word per row and fires a single-cycle
// one-hot FrameStrobe to write the frame into the column config latches.
// Optional feature macro: FRAME_CHECKSUM_EN adds a CHK state that expects
// the XOR of the row words after the last data word.
// Ports:
//   UserCLK     in   sole clock
//   Reset       in   asynchronous active-high reset
//   s_data      in   bitstream word
//   s_valid     in   s_data is valid
//   s_ready     out  word accepted this cycle (decoded from state only)
//   FrameData   out  row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe out  one-hot write pulse, one cycle wide
//   busy        out  high in any state other than IDLE
//   err         out  sticky error, cleared only by Reset
// FrameBitsPerRow must equal the stream width of 32.
module frame_config_loader
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 2
) (
  input  logic                                UserCLK,
  input  logic                                Reset,
  input  logic [31:0]                         s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
  output logic [MaxFramesPerCol-1:0]          FrameStrobe,
  output logic                                busy,
  output logic                                err
);

  localparam int IdxW  = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int RowW  = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int DataW = NumRows * FrameBitsPerRow;

  frame_state_e       state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [DataW-1:0]   frame_data_q, frame_data_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
`ifdef FRAME_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0] chk_acc_q, chk_acc_d;
`endif

  logic                   accept;
  logic                   last_row;
  logic [FRAME_IDX_W-1:0] hdr_idx;
  logic                   idx_in_range;
  logic                   strobe_fire;

  // s_ready depends on the state alone so the source may use it to decide
  // whether to present a word without a combinational loop through s_valid.
  always_comb begin
    s_ready = (state_q == IDLE) || (state_q == HDR) || (state_q == DATA)
`ifdef FRAME_CHECKSUM_EN
              || (state_q == CHK)
`endif
              ;
  end

  assign accept       = s_valid && s_ready;
  assign last_row     = (row_q == RowW'(NumRows - 1));
  assign hdr_idx      = s_data[FRAME_IDX_MSB:FRAME_IDX_LSB];
  assign idx_in_range = (hdr_idx < FRAME_IDX_W'(MaxFramesPerCol));

  // Next-state and datapath decode. FrameData is only ever written in DATA,
  // which keeps it frozen through SETTLE, STROBE and the following HDR cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    row_d        = row_q;
    frame_data_d = frame_data_q;
    err_d        = err_q;
`ifdef FRAME_CHECKSUM_EN
    chk_acc_d    = chk_acc_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept && (s_data == SYNC_WORD)) begin
          state_d = HDR;
        end
      end

      HDR: begin
        if (accept) begin
          if (s_data == DESYNC_WORD) begin
            state_d = IDLE;
          end else if (idx_in_range) begin
            idx_d   = hdr_idx[IdxW-1:0];
            row_d   = '0;
            state_d = DATA;
`ifdef FRAME_CHECKSUM_EN
            chk_acc_d = '0;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (accept) begin
          for (int r = 0; r < NumRows; r++) begin
            if (row_q == RowW'(r)) begin
              frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
            end
          end
          row_d = row_q + RowW'(1);
`ifdef FRAME_CHECKSUM_EN
          chk_acc_d = chk_acc_q ^ s_data;
          if (last_row) begin
            state_d = CHK;
          end
`else
          if (last_row) begin
            state_d = SETTLE;
          end
`endif
        end
      end

`ifdef FRAME_CHECKSUM_EN
      // A bad checksum abandons the frame; FrameData keeps the words
      // already written but no strobe is issued.
      CHK: begin
        if (accept) begin
          if (s_data == chk_acc_q) begin
            state_d = SETTLE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif

      SETTLE: begin
        state_d = STROBE;
      end

      STROBE: begin
        state_d = HDR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Launching the pulse from SETTLE puts it on FrameStrobe exactly while the
  // loader sits in STROBE.
  assign strobe_fire = (state_q == SETTLE);

  frame_strobe_decoder #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .IdxW            (IdxW)
  ) u_strobe_decoder (
    .clk    (UserCLK),
    .rst    (Reset),
    .idx    (idx_q),
    .fire   (strobe_fire),
    .strobe (FrameStrobe)
  );

  // All loader state, cleared asynchronously
  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      row_q        <= '0;
      frame_data_q <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      chk_acc_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      frame_data_q <= frame_data_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
`ifdef FRAME_CHECKSUM_EN
      chk_acc_q    <= chk_acc_d;
`endif
    end
  end

  assign FrameData = frame_data_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// Self-checking bench for frame_config_loader.
// Expected strobes (value, frame data, cycle) are queued as frames are sent
// and matched by a negedge monitor whenever FrameStrobe goes non-zero.
// Define FRAME_CHECKSUM_EN for both RTL and bench to cover the CHK state.
module tb_frame_config_loader;
  import frame_cfg_pkg::*;

  logic        UserCLK = 1'b0;
  logic        Reset;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        busy;
  logic        err;

  int vectorCnt = 0;
  int missCnt   = 0;
  int cycleCnt  = 0;
  int acc;

  typedef struct {
    logic [19:0] strobe;
    logic [63:0] data;
    int          cycle;
  } expT;

  expT         sbQueue[$];
  logic [19:0] prevStrobe = '0;
  logic [63:0] prevData   = '0;

  frame_config_loader #(
    .MaxFramesPerCol (20),
    .FrameBitsPerRow (32),
    .NumRows         (2)
  ) dut (
    .UserCLK     (UserCLK),
    .Reset       (Reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err         (err)
  );

  always #5 UserCLK = ~UserCLK;

  always @(posedge UserCLK) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectorCnt++;
    if (actual !== expected) begin
      missCnt++;
      $display("[TB] FAIL %s: actual=%h required=%h", tag, actual, expected);
    end
  endtask

  // Present one word at a negedge, hold until accepted; optional idle gap first
  task automatic applyStimulus(input logic [31:0] word, input bit gap,
                               output int acceptCycle);
    int waitCnt = 0;
    if (gap) @(negedge UserCLK);
    @(negedge UserCLK);
    s_data  = word;
    s_valid = 1'b1;
    while (!s_ready && waitCnt < 40) begin
      @(negedge UserCLK);
      waitCnt++;
    end
    if (!s_ready) begin
      checkOutput("ready_timeout", s_ready, 1'b1);
      s_valid     = 1'b0;
      acceptCycle = -1;
      return;
    end
    @(posedge UserCLK);
    #1;
    s_valid     = 1'b0;
    acceptCycle = cycleCnt;
  endtask

  // Header + row words (+ checksum); returns at the negedge inside SETTLE
  task automatic sendFrame(input logic [7:0] idx, input logic [31:0] d0,
                           input logic [31:0] d1, input bit gap,
                           input bit expectStrobe);
    int  lastAcc;
    expT e;
    applyStimulus({24'h0, idx}, gap, lastAcc);
    applyStimulus(d0, gap, lastAcc);
    applyStimulus(d1, gap, lastAcc);
`ifdef FRAME_CHECKSUM_EN
    applyStimulus(d0 ^ d1, gap, lastAcc);
`endif
    if (expectStrobe) begin
      e.strobe = 20'(1) << idx;
      e.data   = {d1, d0};
      e.cycle  = lastAcc + 1;
      sbQueue.push_back(e);
    end
    @(negedge UserCLK);
    checkOutput("settle_ready", s_ready, 1'b0);
    checkOutput("settle_strobe", FrameStrobe, 20'h0);
    checkOutput("settle_data", FrameData, {d1, d0});
    checkOutput("settle_busy", busy, 1'b1);
  endtask

  task automatic drainScoreboard();
    int n = 0;
    while (sbQueue.size() != 0 && n < 30) begin
      @(negedge UserCLK);
      n++;
    end
    @(negedge UserCLK);
    checkOutput("strobe_missing", sbQueue.size(), 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, s_ready, 1'b1);
    checkOutput({tag, "_data"}, FrameData, 64'h0);
    checkOutput({tag, "_strobe"}, FrameStrobe, 20'h0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_err"}, err, 1'b0);
  endtask

  // Strobe monitor: matches pulses to the scoreboard and checks the pulse
  // is one cycle wide with data frozen into the following cycle.
  always @(negedge UserCLK) begin : strobeMonitor
    expT e;
    if (prevStrobe != 20'h0) begin
      checkOutput("strobe_width", FrameStrobe, 20'h0);
      checkOutput("post_strobe_ready", s_ready, 1'b1);
      checkOutput("post_strobe_data", FrameData, prevData);
    end
    if (FrameStrobe != 20'h0) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_strobe", FrameStrobe, 20'h0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("strobe_value", FrameStrobe, e.strobe);
        checkOutput("strobe_data", FrameData, e.data);
        checkOutput("strobe_latency", cycleCnt, e.cycle);
        checkOutput("strobe_ready", s_ready, 1'b0);
      end
    end
    prevStrobe = FrameStrobe;
    prevData   = FrameData;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 32'h0;
    repeat (2) @(negedge UserCLK);
    checkResetValues("reset");
    @(negedge UserCLK);
    Reset = 1'b0;

    // Basic frame to index 3
    applyStimulus(SYNC_WORD, 1'b0, acc);
    sendFrame(8'h03, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1);
    drainScoreboard();
    checkOutput("frame1_err", err, 1'b0);
    checkOutput("frame1_busy_hdr", busy, 1'b1);

    // Desync back to IDLE; the following word is discarded
    applyStimulus(DESYNC_WORD, 1'b0, acc);
    applyStimulus(32'h0000_0005, 1'b0, acc);
    repeat (3) @(negedge UserCLK);
    checkOutput("desync_busy", busy, 1'b0);
    checkOutput("desync_err", err, 1'b0);
    checkOutput("desync_ready", s_ready, 1'b1);
    checkOutput("desync_data", FrameData, 64'h2222_2222_1111_1111);

    // Out-of-range header sets err and returns to IDLE
    applyStimulus(SYNC_WORD, 1'b0, acc);
    applyStimulus(32'h0000_0014, 1'b0, acc);
    checkOutput("badidx_err", err, 1'b1);
    checkOutput("badidx_busy", busy, 1'b0);
    applyStimulus(32'h0000_0003, 1'b0, acc);
    applyStimulus(32'h3333_3333, 1'b0, acc);
    applyStimulus(32'h4444_4444, 1'b0, acc);
    repeat (4) @(negedge UserCLK);
    checkOutput("ignored_busy", busy, 1'b0);
    checkOutput("ignored_data", FrameData, 64'h2222_2222_1111_1111);

    // Back-to-back boundary indices with s_valid toggling
    applyStimulus(SYNC_WORD, 1'b1, acc);
    sendFrame(8'd0, 32'hAAAA_5555, 32'h5555_AAAA, 1'b1, 1'b1);
    sendFrame(8'd19, 32'h0123_4567, 32'h89AB_CDEF, 1'b1, 1'b1);
    drainScoreboard();
    checkOutput("toggle_err_sticky", err, 1'b1);

    // Reset during SETTLE drops the strobe in flight
    sendFrame(8'd5, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0);
    Reset = 1'b1;
    @(negedge UserCLK);
    checkResetValues("midreset");
    @(negedge UserCLK);
    Reset = 1'b0;
    applyStimulus(SYNC_WORD, 1'b0, acc);
    sendFrame(8'd7, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 1'b1);
    drainScoreboard();
    checkOutput("fresh_err", err, 1'b0);

`ifdef FRAME_CHECKSUM_EN
    // Matching checksum fires; mismatching checksum errors without a strobe
    sendFrame(8'd2, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 1'b1);
    drainScoreboard();
    applyStimulus(32'h0000_0002, 1'b0, acc);
    applyStimulus(32'hA5A5_0000, 1'b0, acc);
    applyStimulus(32'h0000_5A5A, 1'b0, acc);
    applyStimulus(32'h0000_0000, 1'b0, acc);
    checkOutput("chk_bad_err", err, 1'b1);
    checkOutput("chk_bad_busy", busy, 1'b0);
    checkOutput("chk_bad_data", FrameData, 64'h0000_5A5A_A5A5_0000);
    repeat (4) @(negedge UserCLK);
`endif

    repeat (3) @(negedge UserCLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCnt, missCnt);
    $finish;
  end

endmodule
